// File: rtl/rv32i_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and memory (slave).
interface rv32i_fetch_if;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;

    modport master (output o_iaddr, output o_stb_inst, input i_ack_inst, input i_inst);
    modport slave  (input o_iaddr, input o_stb_inst, output i_ack_inst, output i_inst);
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: one outstanding request, redirect handling, stall hold.
// Define FETCH_SKID_BUF_EN to keep a word acknowledged during a stall instead of refetching it.
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rv32i_fetch_if.master        imem,
    output logic [31:0]          o_inst,
    output logic [31:0]          o_pc,
    output logic                 o_ce,
    input  logic                 i_stall,
    input  logic                 i_change_pc,
    input  logic [31:0]          i_next_pc,
    output logic                 o_flush
);
    localparam int unsigned      XLEN       = 32;
    localparam logic [XLEN-1:0]  PC_INC     = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0]  PC_START   = PC_RESET & ALIGN_MASK;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t          state;
    logic            idle_armed;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect_pc;

`ifdef FETCH_SKID_BUF_EN
    logic [XLEN-1:0] skid_inst;
    logic [XLEN-1:0] skid_pc;
    logic            skid_vld;
`endif

    assign redirect_pc = i_next_pc & ALIGN_MASK;
    assign o_flush     = i_change_pc;

    // FETCH and DROP always have a request on the bus; IDLE and HOLD never do.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            idle_armed      <= 1'b0;
            imem.o_iaddr    <= PC_START;
            imem.o_stb_inst <= 1'b0;
            o_inst          <= '0;
            o_pc            <= '0;
            o_ce            <= 1'b0;
            target          <= '0;
`ifdef FETCH_SKID_BUF_EN
            skid_inst       <= '0;
            skid_pc         <= '0;
            skid_vld        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    idle_armed <= 1'b1;
                    if (i_change_pc) imem.o_iaddr <= redirect_pc;
                    if (idle_armed) begin
                        state           <= FETCH;
                        imem.o_stb_inst <= 1'b1;
                    end
                end

                FETCH: begin
                    if (i_change_pc) begin
                        o_ce <= 1'b0;
`ifdef FETCH_SKID_BUF_EN
                        skid_vld <= 1'b0;
`endif
                        if (imem.i_ack_inst) begin
                            imem.o_iaddr <= redirect_pc;
                        end else begin
                            target <= redirect_pc;
                            state  <= DROP;
                        end
                    end else if (i_stall) begin
                        // Outstanding request stays on the bus until acknowledged.
                        if (imem.i_ack_inst) begin
                            state           <= HOLD;
                            imem.o_stb_inst <= 1'b0;
`ifdef FETCH_SKID_BUF_EN
                            skid_inst       <= imem.i_inst;
                            skid_pc         <= imem.o_iaddr;
                            skid_vld        <= 1'b1;
                            imem.o_iaddr    <= imem.o_iaddr + PC_INC;
`endif
                        end
                    end else if (imem.i_ack_inst) begin
                        o_inst       <= imem.i_inst;
                        o_pc         <= imem.o_iaddr;
                        o_ce         <= 1'b1;
                        imem.o_iaddr <= imem.o_iaddr + PC_INC;
                    end else begin
                        o_ce <= 1'b0;
                    end
                end

                HOLD: begin
                    if (i_change_pc) begin
                        o_ce            <= 1'b0;
                        imem.o_iaddr    <= redirect_pc;
                        imem.o_stb_inst <= 1'b1;
                        state           <= FETCH;
`ifdef FETCH_SKID_BUF_EN
                        skid_vld        <= 1'b0;
`endif
                    end else if (!i_stall) begin
                        imem.o_stb_inst <= 1'b1;
                        state           <= FETCH;
`ifdef FETCH_SKID_BUF_EN
                        if (skid_vld) begin
                            o_inst   <= skid_inst;
                            o_pc     <= skid_pc;
                            o_ce     <= 1'b1;
                            skid_vld <= 1'b0;
                        end else begin
                            o_ce <= 1'b0;
                        end
`else
                        o_ce            <= 1'b0;
`endif
                    end
                end

                DROP: begin
                    // Wait out the stale request; the newest redirect target wins.
                    o_ce <= 1'b0;
                    if (i_change_pc) target <= redirect_pc;
                    if (imem.i_ack_inst) begin
                        imem.o_iaddr <= i_change_pc ? redirect_pc : target;
                        state        <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios plus a randomized run against
// an in-order program-stream model (honours FETCH_SKID_BUF_EN when defined).
`timescale 1ns/1ps
module tb_rv32i_fetch;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_change_pc;
    logic [31:0] i_next_pc;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        o_flush;
    int unsigned errors;
    int unsigned checks;

    rv32i_fetch_if imem ();

    rv32i_fetch #(.PC_RESET(PC_RESET)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .imem        (imem),
        .o_inst      (o_inst),
        .o_pc        (o_pc),
        .o_ce        (o_ce),
        .i_stall     (i_stall),
        .i_change_pc (i_change_pc),
        .i_next_pc   (i_next_pc),
        .o_flush     (o_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_mem(input logic ack);
        imem.i_ack_inst = ack;
        imem.i_inst     = ack ? mem_word(imem.o_iaddr) : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_stall = 1'b0; i_change_pc = 1'b0; i_next_pc = '0;
        drive_mem(1'b0);
        tick(); tick();
        checks++; if (imem.o_stb_inst !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", imem.o_stb_inst); end
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", o_ce); end
        checks++; if (imem.o_iaddr !== PC_RESET) begin errors++; $display("FAIL reset_iaddr: got %h want %h", imem.o_iaddr, PC_RESET); end
        checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", o_inst); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        imem.i_ack_inst = 1'b1; imem.i_inst = 32'hBAD0_0001;   // stray late ack
        tick();
        checks++; if (imem.o_stb_inst !== 1'b0) begin errors++; $display("FAIL idle_stb: got %b want 0", imem.o_stb_inst); end
        tick();
        checks++; if (imem.o_stb_inst !== 1'b1) begin errors++; $display("FAIL first_stb: got %b want 1", imem.o_stb_inst); end
        checks++; if (imem.o_iaddr !== PC_RESET) begin errors++; $display("FAIL first_iaddr: got %h want %h", imem.o_iaddr, PC_RESET); end
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL late_ack_ce: got %b want 0", o_ce); end
        drive_mem(1'b0);
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            drive_mem(1'b1);
            tick();
            checks++; if (o_ce !== 1'b1) begin errors++; $display("FAIL zw_ce[%0d]: got %b want 1", k, o_ce); end
            checks++; if (o_pc !== PC_RESET + 32'(4 * k)) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", k, o_pc, PC_RESET + 32'(4 * k)); end
            checks++; if (o_inst !== mem_word(PC_RESET + 32'(4 * k))) begin errors++; $display("FAIL zw_inst[%0d]: got %h want %h", k, o_inst, mem_word(PC_RESET + 32'(4 * k))); end
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem.o_stb_inst !== 1'b1 || imem.o_iaddr !== 32'h10) begin errors++; $display("FAIL ws_req[%0d]: got stb=%b addr=%h want stb=1 addr=00000010", k, imem.o_stb_inst, imem.o_iaddr); end
            drive_mem(k == 3);
            tick();
            checks++; if (o_ce !== (k == 3)) begin errors++; $display("FAIL ws_ce[%0d]: got %b want %b", k, o_ce, (k == 3)); end
        end
        checks++; if (o_pc !== 32'h10) begin errors++; $display("FAIL ws_pc: got %h want 00000010", o_pc); end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 4; k++) begin drive_mem(1'b1); tick(); end
        checks++; if (imem.o_iaddr !== 32'h24) begin errors++; $display("FAIL rd_pre_iaddr: got %h want 00000024", imem.o_iaddr); end
        drive_mem(1'b0);
        i_change_pc = 1'b1; i_next_pc = 32'h200;
        #1;
        checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL rd_flush_on: got %b want 1", o_flush); end
        tick();
        i_change_pc = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL rd_flush_off: got %b want 0", o_flush); end
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rd_ce0: got %b want 0", o_ce); end
        checks++; if (imem.o_iaddr !== 32'h24 || imem.o_stb_inst !== 1'b1) begin errors++; $display("FAIL rd_hold: got addr=%h stb=%b want 00000024/1", imem.o_iaddr, imem.o_stb_inst); end
        tick();
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rd_ce1: got %b want 0", o_ce); end
        drive_mem(1'b1);                        // late ack for 0x24, must be discarded
        tick();
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rd_stale_ce: got %b want 0", o_ce); end
        checks++; if (imem.o_iaddr !== 32'h200 || imem.o_stb_inst !== 1'b1) begin errors++; $display("FAIL rd_target: got addr=%h stb=%b want 00000200/1", imem.o_iaddr, imem.o_stb_inst); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h200 || o_inst !== mem_word(32'h200)) begin errors++; $display("FAIL rd_first: got ce=%b pc=%h inst=%h want 1/00000200/%h", o_ce, o_pc, o_inst, mem_word(32'h200)); end
    endtask

    task automatic test_stall();
        i_change_pc = 1'b1; i_next_pc = 32'h3C;
        drive_mem(1'b1);
        tick();
        i_change_pc = 1'b0;
        checks++; if (imem.o_iaddr !== 32'h3C || o_ce !== 1'b0) begin errors++; $display("FAIL st_redir: got addr=%h ce=%b want 0000003c/0", imem.o_iaddr, o_ce); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_pc !== 32'h3C || o_ce !== 1'b1 || imem.o_iaddr !== 32'h40) begin errors++; $display("FAIL st_pre: got pc=%h ce=%b addr=%h want 0000003c/1/00000040", o_pc, o_ce, imem.o_iaddr); end
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_mem(k == 0);                   // ack at 0x40 lands in the first stall cycle
            tick();
            checks++; if (o_pc !== 32'h3C || o_ce !== 1'b1 || o_inst !== mem_word(32'h3C)) begin errors++; $display("FAIL st_frozen[%0d]: got pc=%h ce=%b inst=%h want 0000003c/1/%h", k, o_pc, o_ce, o_inst, mem_word(32'h3C)); end
            checks++; if (imem.o_stb_inst !== 1'b0) begin errors++; $display("FAIL st_stb[%0d]: got %b want 0", k, imem.o_stb_inst); end
        end
`ifdef FETCH_SKID_BUF_EN
        checks++; if (imem.o_iaddr !== 32'h44) begin errors++; $display("FAIL st_skid_addr: got %h want 00000044", imem.o_iaddr); end
`else
        checks++; if (imem.o_iaddr !== 32'h40) begin errors++; $display("FAIL st_hold_addr: got %h want 00000040", imem.o_iaddr); end
`endif
        i_stall = 1'b0;
        drive_mem(1'b0);
        tick();
`ifdef FETCH_SKID_BUF_EN
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h40 || o_inst !== mem_word(32'h40)) begin errors++; $display("FAIL st_skid_out: got ce=%b pc=%h inst=%h want 1/00000040/%h", o_ce, o_pc, o_inst, mem_word(32'h40)); end
        checks++; if (imem.o_iaddr !== 32'h44 || imem.o_stb_inst !== 1'b1) begin errors++; $display("FAIL st_resume: got addr=%h stb=%b want 00000044/1", imem.o_iaddr, imem.o_stb_inst); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h44) begin errors++; $display("FAIL st_next: got ce=%b pc=%h want 1/00000044", o_ce, o_pc); end
`else
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL st_rel_ce: got %b want 0", o_ce); end
        checks++; if (imem.o_iaddr !== 32'h40 || imem.o_stb_inst !== 1'b1) begin errors++; $display("FAIL st_refetch: got addr=%h stb=%b want 00000040/1", imem.o_iaddr, imem.o_stb_inst); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== 32'h40 || o_inst !== mem_word(32'h40)) begin errors++; $display("FAIL st_next: got ce=%b pc=%h inst=%h want 1/00000040/%h", o_ce, o_pc, o_inst, mem_word(32'h40)); end
`endif
    endtask

    task automatic test_wrap();
        i_change_pc = 1'b1; i_next_pc = 32'hFFFF_FFFE;
        drive_mem(1'b1);
        tick();
        i_change_pc = 1'b0;
        checks++; if (imem.o_iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffc", imem.o_iaddr); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_pc !== 32'hFFFF_FFFC || o_ce !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h ce=%b want fffffffc/1", o_pc, o_ce); end
        checks++; if (imem.o_iaddr !== 32'h0) begin errors++; $display("FAIL wrap_iaddr: got %h want 00000000", imem.o_iaddr); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_pc !== 32'h0 || o_inst !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_next: got pc=%h inst=%h want 00000000/%h", o_pc, o_inst, mem_word(32'h0)); end
    endtask

    task automatic test_reset_mid();
        i_change_pc = 1'b1; i_next_pc = 32'h7C;
        drive_mem(1'b1);
        tick();
        i_change_pc = 1'b0;
        drive_mem(1'b1);
        tick();
        drive_mem(1'b0);
        tick();
        checks++; if (imem.o_stb_inst !== 1'b1 || imem.o_iaddr !== 32'h80 || o_ce !== 1'b0 || o_pc !== 32'h7C) begin errors++; $display("FAIL rm_pre: got stb=%b addr=%h ce=%b pc=%h want 1/00000080/0/0000007c", imem.o_stb_inst, imem.o_iaddr, o_ce, o_pc); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (imem.o_stb_inst !== 1'b0 || o_ce !== 1'b0) begin errors++; $display("FAIL rm_async_ctl: got stb=%b ce=%b want 0/0", imem.o_stb_inst, o_ce); end
        checks++; if (imem.o_iaddr !== PC_RESET || o_pc !== 32'h0 || o_inst !== 32'h0) begin errors++; $display("FAIL rm_async_data: got addr=%h pc=%h inst=%h want %h/0/0", imem.o_iaddr, o_pc, o_inst, PC_RESET); end
        imem.i_ack_inst = 1'b1; imem.i_inst = 32'hBAD0_0002;   // ack for the abandoned request
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        checks++; if (imem.o_stb_inst !== 1'b0 || o_ce !== 1'b0) begin errors++; $display("FAIL rm_idle: got stb=%b ce=%b want 0/0", imem.o_stb_inst, o_ce); end
        tick();
        checks++; if (imem.o_stb_inst !== 1'b1 || imem.o_iaddr !== PC_RESET || o_ce !== 1'b0) begin errors++; $display("FAIL rm_refetch: got stb=%b addr=%h ce=%b want 1/%h/0", imem.o_stb_inst, imem.o_iaddr, o_ce, PC_RESET); end
        drive_mem(1'b1);
        tick();
        checks++; if (o_ce !== 1'b1 || o_pc !== PC_RESET || o_inst !== mem_word(PC_RESET)) begin errors++; $display("FAIL rm_first: got ce=%b pc=%h inst=%h want 1/%h/%h", o_ce, o_pc, o_inst, PC_RESET, mem_word(PC_RESET)); end
        drive_mem(1'b0);
    endtask

    // Randomized run: delivered words must follow program order from reset/redirect targets.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_iaddr;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic        prev_ce;
        logic        prev_stb;
        logic        prev_ack;
        logic        prev_stall;
        logic        prev_change;
        int unsigned delivered;
        i_rst_n = 1'b0; i_stall = 1'b0; i_change_pc = 1'b0;
        drive_mem(1'b0);
        tick();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_pc = PC_RESET; delivered = 0;
        prev_iaddr = '0; prev_inst = '0; prev_pc = '0;
        prev_ce = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_change = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (prev_change) begin
                checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL rnd_redirect_ce @%0d: got %b want 0", cyc, o_ce); end
            end else if (prev_stall) begin
                checks++; if (o_ce !== prev_ce || o_pc !== prev_pc || o_inst !== prev_inst) begin errors++; $display("FAIL rnd_freeze @%0d: got ce=%b pc=%h inst=%h want %b/%h/%h", cyc, o_ce, o_pc, o_inst, prev_ce, prev_pc, prev_inst); end
            end else if (o_ce === 1'b1) begin
                checks++; if (o_pc !== exp_pc || o_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_order @%0d: got pc=%h inst=%h want %h/%h", cyc, o_pc, o_inst, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (prev_stb && !prev_ack) begin
                checks++; if (imem.o_stb_inst !== 1'b1 || imem.o_iaddr !== prev_iaddr) begin errors++; $display("FAIL rnd_req_stable @%0d: got stb=%b addr=%h want 1/%h", cyc, imem.o_stb_inst, imem.o_iaddr, prev_iaddr); end
            end
            checks++; if (imem.o_iaddr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align @%0d: got %h", cyc, imem.o_iaddr); end
            prev_ce = o_ce; prev_pc = o_pc; prev_inst = o_inst;
            prev_stb = imem.o_stb_inst; prev_iaddr = imem.o_iaddr;
            prev_stall  = ($urandom_range(3) == 0);
            prev_change = ($urandom_range(15) == 0);
            prev_ack    = imem.o_stb_inst && ($urandom_range(2) != 0);
            i_stall = prev_stall; i_change_pc = prev_change; i_next_pc = $urandom;
            drive_mem(prev_ack);
            if (prev_change) exp_pc = i_next_pc & 32'hFFFF_FFFC;
            #1;
            checks++; if (o_flush !== prev_change) begin errors++; $display("FAIL rnd_flush @%0d: got %b want %b", cyc, o_flush, prev_change); end
        end
        checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 200", delivered); end
        i_stall = 1'b0; i_change_pc = 1'b0;
        drive_mem(1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_redirect();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule

// File: doc/rv32i_fetch.md
RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 SHALL: parameter PC_RESET, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL: i_clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL: o_iaddr  output  32  instruction memory address, bits [1:0] always 0.
REQ-005 SHALL: o_stb_inst  output  1  instruction memory request strobe.
REQ-006 SHALL: i_ack_inst  input  1  memory acknowledge; i_inst valid this cycle.
REQ-007 SHALL: i_inst  input  32  instruction word from memory.
REQ-008 SHALL: o_inst  output  32  registered instruction to decode stage.
REQ-009 SHALL: o_pc  output  32  registered address of o_inst.
REQ-010 SHALL: o_ce  output  1  clock enable of decode stage; o_inst/o_pc valid when high.
REQ-011 SHALL: i_stall  input  1  decode or later stage stalled; hold outputs.
REQ-012 SHALL: i_change_pc  input  1  redirect request (branch, jump, trap, mret).
REQ-013 SHALL: i_next_pc  input  32  redirect target, sampled when i_change_pc high.
REQ-014 SHALL: o_flush  output  1  combinational copy of i_change_pc, flushes decode stage.

Function
REQ-015 SHALL: one outstanding request max; o_iaddr and o_stb_inst stable from assertion until the cycle i_ack_inst is sampled high.
REQ-016 SHALL: state machine IDLE, FETCH, HOLD, DROP; IDLE only for the first cycle after reset release, then FETCH with o_stb_inst=1, o_iaddr=PC_RESET.
REQ-017 SHALL: FETCH with i_ack_inst=1, i_stall=0, i_change_pc=0: o_inst<=i_inst, o_pc<=o_iaddr, o_ce<=1, o_iaddr<=o_iaddr+4, o_stb_inst stays 1 (one instruction per cycle at zero-wait memory).
REQ-018 SHALL: FETCH with i_ack_inst=0 and i_stall=0: o_ce<=0 (bubble), o_iaddr held.
REQ-019 SHALL: i_stall=1: o_inst, o_pc, o_ce hold their values; no redirect pending means no o_iaddr advance.
REQ-020 SHALL: ack arriving while i_stall=1: handled per REQ-032/REQ-033; o_stb_inst<=0 until stall release.
REQ-021 SHALL: i_change_pc=1 has priority over i_stall and ack; o_ce<=0 next cycle; target latched as {i_next_pc[31:2],2'b00}.
REQ-022 SHALL: redirect with no request outstanding, or with ack in the same cycle: ack data dropped, next cycle o_iaddr=target, o_stb_inst=1, state FETCH.
REQ-023 SHALL: redirect while request outstanding without ack: state DROP, o_iaddr held until ack, that ack data discarded, next cycle o_iaddr=target.
REQ-024 SHALL: second redirect while in DROP overwrites the latched target; last target wins.
REQ-025 SHALL: address increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-026 SHALL: o_ce never high for a word fetched from an address issued before the most recent redirect.

Reset
REQ-027 SHALL: while i_rst_n=0: o_stb_inst=0, o_ce=0, o_iaddr=PC_RESET, o_inst=0, o_pc=0, state IDLE, latched target and skid buffer cleared.
REQ-028 SHALL: reset asserted mid-request abandons the request; a late ack after reset release before the first strobe is ignored.
REQ-029 SHALL: first o_stb_inst assertion two edges after i_rst_n deasserts (IDLE then FETCH).

Configuration
REQ-030 SHALL: macro FETCH_SKID_BUF_EN selects stall-ack handling.
REQ-031 SHALL: skid buffer is a 32-bit instruction plus 32-bit PC plus valid bit, present only with the macro defined.
REQ-032 SHALL: FETCH_SKID_BUF_EN defined: ack during stall stored in skid, state HOLD, o_iaddr<=o_iaddr+4; on release skid content presented with o_ce<=1 the next cycle and fetch resumes at o_iaddr; redirect clears skid.
REQ-033 SHALL: FETCH_SKID_BUF_EN undefined: ack during stall discarded, state HOLD, o_iaddr held; on release the same address is re-requested.

Verification
REQ-034 SHALL: reset release, zero-wait ack every cycle, words A0..A3 -> o_pc 0,4,8,C on consecutive cycles, o_ce=1 from the cycle after first ack.
REQ-035 SHALL: ack delayed 3 cycles at 0x10 -> o_iaddr=0x10 and o_stb_inst=1 for 4 cycles, o_ce=0 for 3 cycles.
REQ-036 SHALL: i_change_pc=1, i_next_pc=0x200 while request to 0x24 outstanding, ack 2 cycles later -> 0x24 data never on o_inst with o_ce=1, next strobe o_iaddr=0x200, o_flush=1 in redirect cycle only.
REQ-037 SHALL: i_stall=1 for 3 cycles with ack at 0x40 -> outputs frozen; skid on: o_pc=0x40 one cycle after release, no refetch; skid off: 0x40 re-requested.
REQ-038 SHALL: i_next_pc=0xFFFF_FFFE -> o_iaddr=0xFFFF_FFFC, next sequential o_iaddr=0x0000_0000.
REQ-039 SHALL: i_rst_n pulsed low mid-request at 0x80 -> outputs at reset values asynchronously, refetch starts at PC_RESET.
